// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - fetch stage state encodings and opcode constants shared with decode
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_ISSUE  = 2'd0,
        ST_WAIT   = 2'd1,
        ST_HOLD   = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_e;

    localparam logic [4:0] OP_HALT = 5'b00000;
    localparam logic [4:0] OP_NOP  = 5'b00001;

    function automatic logic is_halt(input logic [15:0] word);
        return word[15:11] == OP_HALT;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory read handshake between fetch and imem
interface fetch_unit_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_ack;

    modport master (output imem_req, output imem_addr, input imem_rdata, input imem_ack);
    modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_ack);
endinterface

// File: rtl/fetch_unit_timeout_ctr.sv
// rtl/fetch_unit_timeout_ctr.sv - saturating wait counter with clear/enable and expiry flag
module fetch_timeout_ctr #(
    parameter logic [7:0] MAX = 8'd15
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    logic [7:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= 8'd0;
        end else if (i_clr) begin
            r_cnt <= 8'd0;
        end else if (i_en && (r_cnt != MAX)) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_expired = (r_cnt == MAX);

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-entry fetch stage: PC, imem req/ack, redirect squash, halt, timeout
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800,
    parameter int          MAX_WAIT  = 15
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  imem,
    input  logic          stall,
    input  logic          redirect,
    input  logic [15:0]   redirect_pc,
    output logic [15:0]   instruction,
    output logic [15:0]   pc_plus2,
    output logic          instr_valid,
    output logic          halted,
    output logic          err
);

    fetch_state_e r_state, w_state_nxt;
    logic [15:0]  r_pc, w_pc_nxt;
    logic [15:0]  r_addr, w_addr_nxt;
    logic [15:0]  r_instr, w_instr_nxt;
    logic [15:0]  r_pc_plus2, w_pc_plus2_nxt;
    logic         r_valid, w_valid_nxt;
    logic         r_squash, w_squash_nxt;
    logic         r_err, w_err_nxt;

    logic         w_expired;
    logic         w_xfer;
    logic         w_in_wait;
    logic [15:0]  w_redir_pc;

    assign w_in_wait  = (r_state == ST_WAIT);
    assign w_xfer     = r_valid && !stall;
    assign w_redir_pc = {redirect_pc[15:1], 1'b0};

    fetch_timeout_ctr #(
        .MAX (8'(MAX_WAIT))
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (!w_in_wait || imem.imem_ack),
        .i_en      (w_in_wait),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_ISSUE;
            r_pc       <= RESET_PC;
            r_addr     <= RESET_PC;
            r_instr    <= NOP_INSTR;
            r_pc_plus2 <= 16'h0000;
            r_valid    <= 1'b0;
            r_squash   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_addr     <= w_addr_nxt;
            r_instr    <= w_instr_nxt;
            r_pc_plus2 <= w_pc_plus2_nxt;
            r_valid    <= w_valid_nxt;
            r_squash   <= w_squash_nxt;
            r_err      <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_addr_nxt     = r_addr;
        w_instr_nxt    = r_instr;
        w_pc_plus2_nxt = r_pc_plus2;
        w_valid_nxt    = r_valid;
        w_squash_nxt   = r_squash;
        w_err_nxt      = r_err || (w_in_wait && w_expired);

        // Redirect wins over ack and stall everywhere except HALTED.
        if (redirect && (r_state != ST_HALTED)) begin
            w_pc_nxt    = w_redir_pc;
            w_valid_nxt = 1'b0;
            if (redirect_pc[0]) begin
                w_err_nxt = 1'b1;
            end
        end

        case (r_state)
            ST_ISSUE: begin
                if (!redirect) begin
                    w_addr_nxt  = r_pc;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    // Request stays up with the old address until the memory answers.
                    if (imem.imem_ack) begin
                        w_squash_nxt = 1'b0;
                        w_state_nxt  = ST_ISSUE;
                    end else begin
                        w_squash_nxt = 1'b1;
                    end
                end else if (imem.imem_ack) begin
                    if (r_squash) begin
                        w_squash_nxt = 1'b0;
                        w_state_nxt  = ST_ISSUE;
                    end else begin
                        w_instr_nxt    = imem.imem_rdata;
                        w_pc_plus2_nxt = r_addr + 16'd2;
                        w_pc_nxt       = r_addr + 16'd2;
                        w_valid_nxt    = 1'b1;
                        w_state_nxt    = is_halt(imem.imem_rdata) ? ST_HALTED : ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    w_state_nxt = ST_ISSUE;
                end else if (w_xfer) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_HALTED: begin
                if (w_xfer) begin
                    w_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_ISSUE;
            end
        endcase
    end

    assign imem.imem_req  = w_in_wait;
    assign imem.imem_addr = w_in_wait ? r_addr : r_pc;
    assign instruction    = r_valid ? r_instr : NOP_INSTR;
    assign pc_plus2       = r_pc_plus2;
    assign instr_valid    = r_valid;
    assign halted         = (r_state == ST_HALTED);
    assign err            = r_err;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] instruction;
    logic [15:0] pc_plus2;
    logic        instr_valid;
    logic        halted;
    logic        err;

    int n_vec  = 0;
    int n_miss = 0;

    fetch_unit_if imem_bus ();

    fetch_unit #(
        .RESET_PC  (16'h0000),
        .NOP_INSTR (16'h0800),
        .MAX_WAIT  (15)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem        (imem_bus.master),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instruction (instruction),
        .pc_plus2    (pc_plus2),
        .instr_valid (instr_valid),
        .halted      (halted),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string tag, input logic [15:0] exp_addr);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!imem_bus.imem_req && n < 20);
        check_vec(tag, {15'd0, imem_bus.imem_req}, 32'd1);
        check_vec(tag, {16'd0, imem_bus.imem_addr}, {16'd0, exp_addr});
    endtask

    task automatic ack_word(input logic [15:0] d);
        imem_bus.imem_rdata = d;
        imem_bus.imem_ack   = 1'b1;
        tick();
        imem_bus.imem_ack   = 1'b0;
    endtask

    task automatic do_redirect(input logic [15:0] target);
        redirect    = 1'b1;
        redirect_pc = target;
        tick();
        redirect    = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        int reqs;
        rst                 = 1'b0;
        stall               = 1'b0;
        redirect            = 1'b0;
        redirect_pc         = 16'h0000;
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = 16'h0000;
        tick();
        tick();

        // 1: reset values, back-to-back single-cycle acks
        check_vec("rst_instr", instruction, 16'h0800);
        check_vec("rst_pc_plus2", pc_plus2, 16'h0000);
        check_vec("rst_valid", instr_valid, 1'b0);
        check_vec("rst_req", imem_bus.imem_req, 1'b0);
        check_vec("rst_addr", imem_bus.imem_addr, 16'h0000);
        check_vec("rst_halted", halted, 1'b0);
        check_vec("rst_err", err, 1'b0);
        rst = 1'b1;
        wait_req("t1_req0", 16'h0000);
        ack_word(16'h4001);
        check_vec("t1_valid0", instr_valid, 1'b1);
        check_vec("t1_instr0", instruction, 16'h4001);
        check_vec("t1_pp2_0", pc_plus2, 16'h0002);
        tick();
        check_vec("t1_nop_after_xfer", instruction, 16'h0800);
        check_vec("t1_valid_after_xfer", instr_valid, 1'b0);
        wait_req("t1_req1", 16'h0002);
        ack_word(16'h4002);
        check_vec("t1_instr1", instruction, 16'h4002);
        check_vec("t1_pp2_1", pc_plus2, 16'h0004);

        // 2: slow ack, stall holds outputs, no request until transfer
        wait_req("t2_req", 16'h0004);
        tick(); tick(); tick();
        check_vec("t2_req_held", imem_bus.imem_req, 1'b1);
        check_vec("t2_addr_held", imem_bus.imem_addr, 16'h0004);
        check_vec("t2_no_valid_yet", instr_valid, 1'b0);
        stall = 1'b1;
        ack_word(16'h4003);
        check_vec("t2_valid", instr_valid, 1'b1);
        tick();
        check_vec("t2_stall_instr", instruction, 16'h4003);
        check_vec("t2_stall_pp2", pc_plus2, 16'h0006);
        tick();
        check_vec("t2_stall_valid", instr_valid, 1'b1);
        check_vec("t2_stall_noreq", imem_bus.imem_req, 1'b0);
        stall = 1'b0;
        tick();
        check_vec("t2_xfer_valid", instr_valid, 1'b0);
        check_vec("t2_xfer_noreq", imem_bus.imem_req, 1'b0);

        // 3: redirect while waiting squashes the returning word
        wait_req("t3_req", 16'h0006);
        do_redirect(16'h0040);
        check_vec("t3_req_kept", imem_bus.imem_req, 1'b1);
        check_vec("t3_addr_kept", imem_bus.imem_addr, 16'h0006);
        ack_word(16'h4444);
        check_vec("t3_dropped", instr_valid, 1'b0);
        wait_req("t3_req_target", 16'h0040);
        ack_word(16'h4005);
        check_vec("t3_instr", instruction, 16'h4005);
        check_vec("t3_pp2", pc_plus2, 16'h0042);

        // 4: HALT fetched once, then nothing
        wait_req("t4_req", 16'h0042);
        ack_word(16'h0000);
        check_vec("t4_valid", instr_valid, 1'b1);
        check_vec("t4_instr", instruction, 16'h0000);
        check_vec("t4_halted", halted, 1'b1);
        check_vec("t4_pp2", pc_plus2, 16'h0044);
        tick();
        check_vec("t4_valid_once", instr_valid, 1'b0);
        do_redirect(16'h0080);
        reqs = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (imem_bus.imem_req) reqs++;
        end
        check_vec("t4_no_req", reqs, 0);
        check_vec("t4_still_halted", halted, 1'b1);
        check_vec("t4_pc_ignores_redirect", imem_bus.imem_addr, 16'h0044);

        // 5: misaligned redirect
        do_reset();
        check_vec("t5_err_clear", err, 1'b0);
        check_vec("t5_halt_clear", halted, 1'b0);
        wait_req("t5_req", 16'h0000);
        do_redirect(16'h0013);
        check_vec("t5_err_misalign", err, 1'b1);
        ack_word(16'h1234);
        wait_req("t5_req_aligned", 16'h0012);
        check_vec("t5_err_sticky", err, 1'b1);

        // 6: PC wraps from FFFE to 0000
        do_reset();
        wait_req("t6_req", 16'h0000);
        do_redirect(16'hFFFE);
        ack_word(16'h0000);
        check_vec("t6_squash_not_halt", halted, 1'b0);
        wait_req("t6_req_top", 16'hFFFE);
        ack_word(16'h4006);
        check_vec("t6_valid", instr_valid, 1'b1);
        check_vec("t6_pp2_wrap", pc_plus2, 16'h0000);
        check_vec("t6_no_err", err, 1'b0);
        wait_req("t6_req_wrap", 16'h0000);

        // timeout, then asynchronous reset mid-WAIT and a late ack
        for (int i = 0; i < 5; i++) tick();
        check_vec("to_err_early", err, 1'b0);
        for (int i = 0; i < 15; i++) tick();
        check_vec("to_err", err, 1'b1);
        check_vec("to_still_wait", imem_bus.imem_req, 1'b1);
        rst = 1'b0;
        #1;
        check_vec("arst_req", imem_bus.imem_req, 1'b0);
        check_vec("arst_err", err, 1'b0);
        check_vec("arst_addr", imem_bus.imem_addr, 16'h0000);
        check_vec("arst_instr", instruction, 16'h0800);
        tick();
        rst = 1'b1;
        imem_bus.imem_rdata = 16'h0000;
        imem_bus.imem_ack   = 1'b1;
        tick();
        imem_bus.imem_ack   = 1'b0;
        check_vec("late_ack_valid", instr_valid, 1'b0);
        check_vec("late_ack_halted", halted, 1'b0);
        check_vec("late_ack_req", imem_bus.imem_req, 1'b1);
        check_vec("late_ack_addr", imem_bus.imem_addr, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
